du_word_sender: RTL and testbench

DU_WORD_SENDER -- requirements
Module: du_word_sender

---
 rtl/du_word_sender_pkg.sv | 25 ++
 rtl/du_sync_fifo.sv | 58 +++++
 rtl/du_word_sender.sv | 149 ++++++++++++++
 tb/tb_du_word_sender.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/du_word_sender_pkg.sv
// Shared parameters for the word sender: data widths, FIFO geometry and FSM encodings.
package du_word_sender_pkg;

   localparam int unsigned NB_DATA_DEF    = 32;
   localparam int unsigned N_BITS_DEF     = 8;
   localparam int unsigned FIFO_DEPTH_DEF = 4;
   localparam int unsigned ADDRWIDTH      = $clog2(FIFO_DEPTH_DEF);
   localparam int unsigned NB_CNT         = 3;
   localparam int unsigned NB_IDX         = 2;

   localparam logic [NB_CNT-1:0] MAX_BYTES = 3'd4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      START     = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   // A word may carry 1..MAX_BYTES bytes; anything else is rejected at LOAD.
   function automatic logic count_legal(input logic [NB_CNT-1:0] n);
      return (n != '0) && (n <= MAX_BYTES);
   endfunction

endpackage

// File: rtl/du_sync_fifo.sv
// Single-clock FIFO with registered occupancy; pointers wrap modulo DEPTH (power of two).
module du_sync_fifo #(
   parameter int unsigned WIDTH = 35,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [AW:0]      count_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             push_ok_c;
   logic             pop_ok_c;

   // A full FIFO refuses a push even when a pop happens in the same cycle.
   assign push_ok_c = push_i && (count_q != (AW+1)'(DEPTH));
   assign pop_ok_c  = pop_i && (count_q != '0);

   always_ff @(posedge clk) begin
      if (push_ok_c) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok_c) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_ok_c) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push_ok_c, pop_ok_c})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/du_word_sender.sv
// Queues words and streams each one LSB-first as 1..4 bytes to a UART transmitter.
module du_word_sender
   import du_word_sender_pkg::*;
#(
   parameter int unsigned NB_DATA    = NB_DATA_DEF,
   parameter int unsigned N_BITS     = N_BITS_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_valid,
   input  logic [NB_DATA-1:0] i_data,
   input  logic [2:0]         i_nbytes,
   output logic               o_ready,
   output logic [N_BITS-1:0]  o_tx_data,
   output logic               o_tx_start,
   input  logic               i_tx_done,
   output logic               o_word_done,
   output logic               o_err,
   output logic               o_busy
);

   localparam int unsigned NB_ENTRY = NB_DATA + NB_CNT;
   localparam int unsigned AW       = $clog2(FIFO_DEPTH);

   logic [NB_ENTRY-1:0] fifo_rdata;
   logic [AW:0]         fifo_count;
   logic                fifo_empty;
   logic                fifo_pop_c;
   logic                push_c;
   logic [NB_DATA-1:0]  head_data_c;
   logic [NB_CNT-1:0]   head_nbytes_c;
   logic                last_byte_c;

   state_t              state_q, state_d;
   logic [NB_DATA-1:0]  word_q, word_d;
   logic [NB_CNT-1:0]   cnt_q, cnt_d;
   logic [NB_IDX-1:0]   idx_q, idx_d;
   logic [N_BITS-1:0]   tx_data_q, tx_data_d;
   logic                tx_start_q, tx_start_d;
   logic                word_done_q, word_done_d;
   logic                err_q, err_d;

   function automatic logic [N_BITS-1:0] sel_byte(input logic [NB_DATA-1:0] w,
                                                  input logic [NB_IDX-1:0]  i);
      return N_BITS'(w >> (N_BITS * i));
   endfunction

   assign push_c = i_valid && o_ready;

   du_sync_fifo #(
      .WIDTH (NB_ENTRY),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (i_clock),
      .rst_n   (i_reset),
      .push_i  (push_c),
      .wdata_i ({i_nbytes, i_data}),
      .pop_i   (fifo_pop_c),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .empty_o (fifo_empty)
   );

   assign head_data_c   = fifo_rdata[NB_DATA-1:0];
   assign head_nbytes_c = fifo_rdata[NB_ENTRY-1:NB_DATA];
   assign last_byte_c   = ({1'b0, idx_q} == (cnt_q - 3'd1));

   // Next-state, byte mux and pulse generation; pulses are registered one cycle ahead.
   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      tx_data_d   = tx_data_q;
      tx_start_d  = 1'b0;
      word_done_d = 1'b0;
      err_d       = 1'b0;
      fifo_pop_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            fifo_pop_c = 1'b1;
            word_d     = head_data_c;
            cnt_d      = head_nbytes_c;
            idx_d      = '0;
            if (count_legal(head_nbytes_c)) begin
               state_d    = START;
               tx_start_d = 1'b1;
               tx_data_d  = sel_byte(head_data_c, '0);
            end else begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         START: begin
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (i_tx_done) begin
               if (last_byte_c) begin
                  state_d     = IDLE;
                  word_done_d = 1'b1;
               end else begin
                  state_d    = START;
                  idx_d      = idx_q + 2'd1;
                  tx_start_d = 1'b1;
                  tx_data_d  = sel_byte(word_q, idx_q + 2'd1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q     <= IDLE;
         word_q      <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         tx_data_q   <= '0;
         tx_start_q  <= 1'b0;
         word_done_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
         word_done_q <= word_done_d;
         err_q       <= err_d;
      end
   end

   assign o_ready     = (fifo_count < (AW+1)'(FIFO_DEPTH));
   assign o_busy      = (state_q != IDLE) || !fifo_empty;
   assign o_tx_data   = tx_data_q;
   assign o_tx_start  = tx_start_q;
   assign o_word_done = word_done_q;
   assign o_err       = err_q;

endmodule

// File: tb/tb_du_word_sender.sv
// Scoreboard bench for du_word_sender: directed scenarios followed by randomized traffic.
module tb_du_word_sender;

   localparam int EV_START = 0;
   localparam int EV_DONE  = 1;
   localparam int EV_ERR   = 2;

   typedef struct {
      int         kind;
      logic [7:0] b;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid;
   logic [31:0] i_data;
   logic [2:0]  i_nbytes;
   logic        o_ready;
   logic [7:0]  o_tx_data;
   logic        o_tx_start;
   logic        i_tx_done;
   logic        o_word_done;
   logic        o_err;
   logic        o_busy;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  starts_seen = 0;
   int  dones_given = 0;
   int  abandoned   = 0;
   int  n_wdone = 0;
   int  n_errp  = 0;
   int  rst_gen = 0;
   int  man_req = 0;
   int  hold_gen = 0;
   int  resp_delay = 0;
   bit  resp_en = 1'b1;
   bit  spurious = 1'b0;
   logic [7:0] hold_byte = 8'h00;

   always #5 clk = ~clk;

   du_word_sender dut (
      .i_clock     (clk),
      .i_reset     (rst_n),
      .i_valid     (i_valid),
      .i_data      (i_data),
      .i_nbytes    (i_nbytes),
      .o_ready     (o_ready),
      .o_tx_data   (o_tx_data),
      .o_tx_start  (o_tx_start),
      .i_tx_done   (i_tx_done),
      .o_word_done (o_word_done),
      .o_err       (o_err),
      .o_busy      (o_busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference behaviour: a legal word yields its bytes LSB first then a done; otherwise one error.
   function automatic void model_accept(input logic [31:0] d, input logic [2:0] nb);
      ev_t e;
      if (nb >= 3'd1 && nb <= 3'd4) begin
         for (int i = 0; i < int'(nb); i++) begin
            e.kind = EV_START;
            e.b    = d[8*i +: 8];
            exp_q.push_back(e);
         end
         e.kind = EV_DONE;
         e.b    = 8'h00;
         exp_q.push_back(e);
      end else begin
         e.kind = EV_ERR;
         e.b    = 8'h00;
         exp_q.push_back(e);
      end
   endfunction

   task automatic expect_ev(input int kind, input logic [7:0] b);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_event: got kind %0d byte %0h, expected none", kind, b);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", 64'(kind), 64'(e.kind));
         if (kind == EV_START && e.kind == EV_START) begin
            chk("tx_byte", 64'(b), 64'(e.b));
         end
      end
   endtask

   // Monitor: compare every DUT pulse against the scoreboard queue.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (o_word_done) begin
               n_wdone++;
               expect_ev(EV_DONE, 8'h00);
            end
            if (o_err) begin
               n_errp++;
               expect_ev(EV_ERR, 8'h00);
            end
            if (o_tx_start) begin
               chk("start_before_ack", 64'(starts_seen - dones_given - abandoned), 64'(0));
               expect_ev(EV_START, o_tx_data);
               starts_seen++;
               hold_byte = o_tx_data;
               hold_gen  = rst_gen;
            end else if (starts_seen != dones_given + abandoned && hold_gen == rst_gen) begin
               chk("tx_data_hold", 64'(o_tx_data), 64'(hold_byte));
            end
         end
      end
   end

   task automatic serve();
      int g;
      int d;
      g = rst_gen;
      if (spurious) begin
         i_tx_done = 1'b1;
         @(negedge clk);
         i_tx_done = 1'b0;
      end
      d = (resp_delay != 0) ? resp_delay : int'($urandom_range(1, 6));
      while (!resp_en && g == rst_gen) @(negedge clk);
      for (int i = 0; i < d && g == rst_gen; i++) @(negedge clk);
      if (g == rst_gen) begin
         i_tx_done = 1'b1;
         dones_given++;
         @(negedge clk);
         i_tx_done = 1'b0;
      end else begin
         abandoned++;
      end
   endtask

   // UART transmitter stand-in: acknowledges each start, plus manual stray pulses on request.
   initial begin
      int man_seen;
      man_seen  = 0;
      i_tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (man_req != man_seen) begin
            man_seen  = man_req;
            i_tx_done = 1'b1;
            @(negedge clk);
            i_tx_done = 1'b0;
         end
         while (o_tx_start && rst_n) serve();
      end
   end

   task automatic push(input logic [31:0] d, input logic [2:0] nb);
      @(negedge clk);
      i_valid  = 1'b1;
      i_data   = d;
      i_nbytes = nb;
      if (o_ready) model_accept(d, nb);
   endtask

   task automatic idle_in();
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget, input string name);
      for (int i = 0; i < budget && (exp_q.size() != 0 || o_busy); i++) @(negedge clk);
      chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
      chk({name, "_busy"}, 64'(o_busy), 64'(0));
   endtask

   function automatic logic [2:0] pick_nb();
      int r;
      r = int'($urandom_range(0, 11));
      if (r < 8) return 3'(1 + r % 4);
      if (r == 8) return 3'd0;
      return 3'(5 + r % 3);
   endfunction

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
   endtask

   initial begin
      repeat (60000) @(posedge clk);
      n_bad++;
      $display("FAIL watchdog: got no completion, expected finish within cycle budget");
      summary();
      $finish;
   end

   initial begin
      int s0;
      int w0;
      int e0;
      int gap;
      i_valid  = 1'b0;
      i_data   = '0;
      i_nbytes = '0;
      rst_n    = 1'b1;

      // Asynchronous reset values, checked before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", 64'(o_ready), 64'(1));
      chk("rst_busy", 64'(o_busy), 64'(0));
      chk("rst_tx_start", 64'(o_tx_start), 64'(0));
      chk("rst_tx_data", 64'(o_tx_data), 64'(0));
      chk("rst_word_done", 64'(o_word_done), 64'(0));
      chk("rst_err", 64'(o_err), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single 4-byte word, done 10 cycles after each start.
      resp_delay = 10;
      s0 = starts_seen;
      w0 = n_wdone;
      push(32'hA1B2C3D4, 3'd4);
      idle_in();
      wait_drain(500, "single_word");
      chk("single_word_starts", 64'(starts_seen - s0), 64'(4));
      chk("single_word_done", 64'(n_wdone - w0), 64'(1));
      resp_delay = 0;

      // Short word.
      s0 = starts_seen;
      w0 = n_wdone;
      push(32'h00000042, 3'd1);
      idle_in();
      wait_drain(200, "short_word");
      chk("short_word_starts", 64'(starts_seen - s0), 64'(1));
      chk("short_word_done", 64'(n_wdone - w0), 64'(1));

      // Illegal count followed by a legal word.
      s0 = starts_seen;
      e0 = n_errp;
      push(32'h11223344, 3'd0);
      push(32'h00000055, 3'd1);
      idle_in();
      wait_drain(200, "illegal_count");
      chk("illegal_err_pulses", 64'(n_errp - e0), 64'(1));
      chk("illegal_starts", 64'(starts_seen - s0), 64'(1));

      // Full FIFO while the transmitter is stalled on an in-flight word.
      resp_en = 1'b0;
      s0 = starts_seen;
      push(32'h0000BEEF, 3'd2);
      idle_in();
      for (int i = 0; i < 50 && starts_seen == s0; i++) @(negedge clk);
      chk("stall_first_start", 64'(starts_seen - s0), 64'(1));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("full_ready_before_push", 64'(o_ready), 64'(k < 4));
         i_valid  = 1'b1;
         i_data   = 32'h10203040 + 32'(k);
         i_nbytes = 3'(1 + k % 4);
         if (o_ready) model_accept(i_data, i_nbytes);
      end
      idle_in();
      chk("full_ready_low", 64'(o_ready), 64'(0));
      chk("full_busy", 64'(o_busy), 64'(1));
      resp_en = 1'b1;
      wait_drain(2000, "full_fifo");

      // Reset in the middle of a word.
      resp_delay = 10;
      s0 = starts_seen;
      push(32'hA1B2C3D4, 3'd4);
      idle_in();
      for (int i = 0; i < 200 && starts_seen < s0 + 2; i++) @(negedge clk);
      chk("midword_two_starts", 64'(starts_seen - s0), 64'(2));
      #2 rst_n = 1'b0;
      rst_gen++;
      #1;
      exp_q.delete();
      chk("midword_rst_busy", 64'(o_busy), 64'(0));
      chk("midword_rst_ready", 64'(o_ready), 64'(1));
      chk("midword_rst_start", 64'(o_tx_start), 64'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      resp_delay = 0;
      s0 = starts_seen;
      man_req++;
      repeat (20) @(negedge clk);
      chk("midword_no_more_starts", 64'(starts_seen - s0), 64'(0));
      chk("midword_busy_after", 64'(o_busy), 64'(0));
      chk("midword_ready_after", 64'(o_ready), 64'(1));

      // Stray done while idle, then while in START.
      s0 = starts_seen;
      man_req++;
      repeat (10) @(negedge clk);
      chk("idle_done_no_start", 64'(starts_seen - s0), 64'(0));
      chk("idle_done_busy", 64'(o_busy), 64'(0));
      spurious = 1'b1;
      push(32'hCAFEF00D, 3'd4);
      idle_in();
      wait_drain(500, "spurious_done");
      chk("spurious_starts", 64'(starts_seen - s0), 64'(4));
      spurious = 1'b0;

      // Randomized traffic.
      for (int k = 0; k < 200; k++) begin
         gap = int'($urandom_range(0, 3));
         spurious = ($urandom_range(0, 7) == 0);
         repeat (gap) idle_in();
         push($urandom, pick_nb());
      end
      idle_in();
      spurious = 1'b0;
      wait_drain(20000, "random");

      summary();
      $finish;
   end

endmodule
